// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg
//   Shared definitions for the expansion-ROM loader:
//   - state_t    : loader FSM encoding (also exported on the debug port)
//   - SIG0/SIG1  : required values of image bytes 0 and 1
//   - UNIT_BYTES : size of one length unit declared in image byte 2
package rom_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_FILL    = 3'd2,
        ST_FIX_RD  = 3'd3,
        ST_FIX_CAP = 3'd4,
        ST_FIX_WR  = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [7:0] SIG0       = 8'h55;
    localparam logic [7:0] SIG1       = 8'hAA;
    localparam int         UNIT_BYTES = 512;

endpackage

// File: rtl/rom_loader_if.sv
// rom_loader_if
//   Bundles the byte-stream input and the RAM port of the ROM loader.
//   Stream handshake: a byte is transferred on a rising clock edge where
//   in_valid and in_ready are both high; in_data/in_last are only meaningful
//   while in_valid is high and must be held until that edge.
//   modport master : the loader (consumes the stream, drives the RAM port)
//   modport slave  : the environment (stream source and the RAM itself)
//   Signals:
//     in_data[7:0], in_valid, in_last  stream byte, valid, final-byte marker
//     in_ready                         loader accepts bytes
//     rom_address, rom_din             RAM word address / write data
//     rom_wren, rom_enable             RAM write enable / port enable
//     rom_dout[31:0]                   RAM read data (one cycle after read edge)
interface rom_loader_if #(
    parameter int ADDR_W = 9
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] rom_address;
    logic [31:0]       rom_din;
    logic              rom_wren;
    logic              rom_enable;
    logic [31:0]       rom_dout;

    modport master (
        input  in_data, in_valid, in_last, rom_dout,
        output in_ready, rom_address, rom_din, rom_wren, rom_enable
    );

    modport slave (
        output in_data, in_valid, in_last, rom_dout,
        input  in_ready, rom_address, rom_din, rom_wren, rom_enable
    );

endinterface

// File: rtl/rom_loader.sv
// rom_loader
//   Writer side of the 512x32 expansion-ROM RAM. Packs an incoming byte stream
//   little-endian into 32-bit words, zero-fills up to the image length declared
//   in header byte 2 (512-byte units) and patches the final image byte so the
//   8-bit sum of all image bytes is zero.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     start        one-cycle pulse, begins a load when idle
//     bus          rom_loader_if.master: byte stream in, RAM port out
//     busy         high from start until the cycle after done
//     done         one-cycle completion pulse
//     err_sig      header signature mismatch (sticky until next start)
//     err_len      bad/missing length byte or stream overrun (sticky)
//     checksum     value written into the final image byte
//     dbg_state    current FSM state
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int MAX_UNITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    rom_loader_if.master  bus,
    output logic          busy,
    output logic          done,
    output logic          err_sig,
    output logic          err_len,
    output logic [7:0]    checksum,
    output state_t        dbg_state
);

    // Byte index needs one bit more than the byte address so it can hold N
    // itself (it saturates there once the image is full).
    localparam int IDX_W  = ADDR_W + 3;
    localparam int UNIT_W = $clog2(MAX_UNITS + 1);
    localparam int WPU    = UNIT_BYTES / 4;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        pack;
    logic [7:0]         sum;
    logic [UNIT_W-1:0]  units;
    logic [ADDR_W-1:0]  fill_addr;
    logic [23:0]        captured;
    logic               cap_wait;

    logic               accept;
    logic               in_range;
    logic               sum_en;
    logic               sig_bad;
    logic               len_bad;
    logic [1:0]         lane;
    logic [31:0]        pack_nx;
    logic [UNIT_W-1:0]  units_nx;
    logic [IDX_W-1:0]   n_bytes;
    logic [IDX_W-1:0]   nwords_nx;
    logic [IDX_W-1:0]   next_word;
    logic [ADDR_W-1:0]  last_word;

    assign dbg_state = state;

    always_comb begin
        accept    = (state == ST_LOAD) && bus.in_valid && bus.in_ready;
        lane      = idx[1:0];
        n_bytes   = IDX_W'(units) * IDX_W'(UNIT_BYTES);
        last_word = ADDR_W'((n_bytes >> 2) - IDX_W'(1));
        in_range  = idx < n_bytes;
        // The final image byte is replaced by the checksum, so it is not summed.
        sum_en    = idx < (n_bytes - IDX_W'(1));

        // Lanes above the current one are already zero: pack is cleared on
        // every word write, which gives the zero-padded final partial word.
        pack_nx                  = pack;
        pack_nx[8*lane +: 8]     = bus.in_data;

        units_nx = units;
        len_bad  = 1'b0;
        if (idx == IDX_W'(2)) begin
            if (bus.in_data == 8'd0 || bus.in_data > 8'(MAX_UNITS)) begin
                units_nx = UNIT_W'(MAX_UNITS);
                len_bad  = 1'b1;
            end else begin
                units_nx = bus.in_data[UNIT_W-1:0];
            end
        end
        if (bus.in_last && idx < IDX_W'(2)) len_bad = 1'b1;
        if (!in_range)                       len_bad = 1'b1;

        sig_bad = err_sig
                || (idx == IDX_W'(0) && bus.in_data != SIG0)
                || (idx == IDX_W'(1) && bus.in_data != SIG1);

        // Uses the length as it will be after this byte, in case the final
        // stream byte is the length byte itself.
        nwords_nx = IDX_W'(units_nx) * IDX_W'(WPU);
        // First word not covered by the stream. When idx has saturated at N
        // this is beyond the image, so no fill is started.
        next_word = (idx >> 2) + IDX_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            idx             <= '0;
            pack            <= '0;
            sum             <= '0;
            units           <= '0;
            fill_addr       <= '0;
            captured        <= '0;
            cap_wait        <= 1'b0;
            bus.in_ready    <= 1'b0;
            bus.rom_address <= '0;
            bus.rom_din     <= '0;
            bus.rom_wren    <= 1'b0;
            bus.rom_enable  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_sig         <= 1'b0;
            err_len         <= 1'b0;
            checksum        <= '0;
        end else begin
            bus.rom_wren   <= 1'b0;
            bus.rom_enable <= 1'b0;
            done           <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err_sig      <= 1'b0;
                        err_len      <= 1'b0;
                        checksum     <= '0;
                        idx          <= '0;
                        pack         <= '0;
                        sum          <= '0;
                        // Assume the largest image until byte 2 says otherwise.
                        units        <= UNIT_W'(MAX_UNITS);
                        busy         <= 1'b1;
                        bus.in_ready <= 1'b1;
                        state        <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (accept) begin
                        if (sum_en)  sum     <= sum + bus.in_data;
                        if (len_bad) err_len <= 1'b1;
                        if (sig_bad) err_sig <= 1'b1;
                        units <= units_nx;

                        // Bytes past the image are accepted and dropped.
                        if (in_range) begin
                            idx <= idx + IDX_W'(1);
                            if (lane == 2'd3 || bus.in_last) begin
                                bus.rom_wren    <= 1'b1;
                                bus.rom_enable  <= 1'b1;
                                bus.rom_address <= idx[ADDR_W+1:2];
                                bus.rom_din     <= pack_nx;
                                pack            <= '0;
                            end else begin
                                pack <= pack_nx;
                            end
                        end

                        if (bus.in_last) begin
                            bus.in_ready <= 1'b0;
                            if (sig_bad) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else if (next_word < nwords_nx) begin
                                fill_addr <= ADDR_W'(next_word);
                                state     <= ST_FILL;
                            end else begin
                                state <= ST_FIX_RD;
                            end
                        end
                    end
                end

                ST_FILL: begin
                    bus.rom_wren    <= 1'b1;
                    bus.rom_enable  <= 1'b1;
                    bus.rom_address <= fill_addr;
                    bus.rom_din     <= '0;
                    if (fill_addr == last_word) state <= ST_FIX_RD;
                    else fill_addr <= fill_addr + ADDR_W'(1);
                end

                ST_FIX_RD: begin
                    bus.rom_enable  <= 1'b1;
                    bus.rom_address <= last_word;
                    cap_wait        <= 1'b0;
                    state           <= ST_FIX_CAP;
                end

                // The read request is on the port for the first FIX_CAP cycle;
                // the RAM samples it at the end of that cycle, so rom_dout is
                // valid one cycle later.
                ST_FIX_CAP: begin
                    if (!cap_wait) begin
                        cap_wait <= 1'b1;
                    end else begin
                        captured <= bus.rom_dout[23:0];
                        state    <= ST_FIX_WR;
                    end
                end

                ST_FIX_WR: begin
                    bus.rom_wren    <= 1'b1;
                    bus.rom_enable  <= 1'b1;
                    bus.rom_address <= last_word;
                    bus.rom_din     <= {8'd0 - sum, captured};
                    checksum        <= 8'd0 - sum;
                    done            <= 1'b1;
                    state           <= ST_DONE;
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader
//   Directed bench for rom_loader: drives byte streams through the interface,
//   models the external 512x32 synchronous RAM, and checks RAM contents,
//   write/read counts, flags and checksum against hand-computed values.
module tb_rom_loader;
    import rom_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        err_sig;
    logic        err_len;
    logic [7:0]  checksum;
    state_t      dbg_state;

    rom_loader_if #(.ADDR_W(9)) bus ();

    rom_loader #(.ADDR_W(9), .MAX_UNITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus.master),
        .busy      (busy),
        .done      (done),
        .err_sig   (err_sig),
        .err_len   (err_len),
        .checksum  (checksum),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- RAM model and port monitor ----------------
    logic [31:0] mem [0:511];
    logic        clr_req = 1'b0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [8:0]  last_wr_addr = '0;
    logic [8:0]  last_rd_addr = '0;

    always @(posedge clk) begin
        if (clr_req) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'hDEADBEEF;
        end else if (bus.rom_enable && bus.rom_wren) begin
            mem[bus.rom_address] <= bus.rom_din;
            wr_cnt               <= wr_cnt + 1;
            last_wr_addr         <= bus.rom_address;
        end
        if (bus.rom_enable && !bus.rom_wren) begin
            bus.rom_dout <= mem[bus.rom_address];
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= bus.rom_address;
        end
    end

    // ---------------- scoreboard bookkeeping ----------------
    int          tests = 0;
    int          fails = 0;
    int          rdy_miss = 0;
    int          w0;
    int          r0;
    int          diffs;
    int          bsum;
    logic [31:0] ref_mem [0:127];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_mem();
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        int w;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        if (!bus.in_ready) rdy_miss++;
        w = 0;
        while (!bus.in_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $error("FAIL ready_timeout: observed in_ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Waits for the done pulse, then checks busy drops the following cycle.
    task automatic wait_done(input string tag);
        int c;
        c = 0;
        @(negedge clk);
        while (!done && c < 4000) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        check({tag, "_busy_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    function automatic logic [7:0] t1_byte(input int i);
        logic [31:0] v;
        v = i;
        if (i == 0) return 8'h55;
        if (i == 1) return 8'hAA;
        if (i == 2) return 8'h01;
        return v[7:0];
    endfunction

    task automatic run_test1(input int max_gap);
        for (int i = 0; i < 512; i++)
            send_byte(t1_byte(i), i == 511, $urandom_range(0, max_gap));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ctrl", {25'd0, busy, done, err_sig, err_len, bus.in_ready, bus.rom_wren, bus.rom_enable}, 32'd0);
        check("rst_cks", {24'd0, checksum}, 32'd0);
        check("rst_addr_din", {23'd0, bus.rom_address} | bus.rom_din, 32'd0);
        check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        rst = 1'b0;

        // A byte offered while idle is not accepted
        @(negedge clk);
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("idle_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;

        // Test 1: full 512-byte image, length 1 unit
        clear_mem();
        w0 = wr_cnt; r0 = rd_cnt;
        pulse_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        run_test1(0);
        wait_done("t1");
        check("t1_writes", wr_cnt - w0, 32'd129);
        check("t1_reads", rd_cnt - r0, 32'd1);
        check("t1_rd_addr", {23'd0, last_rd_addr}, 32'd127);
        check("t1_w0", mem[0], 32'h0301AA55);
        check("t1_w1", mem[1], 32'h07060504);
        // bytes 508..510 = FC FD FE, byte 511 patched to 0x02
        check("t1_w127", mem[127], 32'h02FEFDFC);
        check("t1_w128", mem[128], 32'hDEADBEEF);
        check("t1_cks", {24'd0, checksum}, 32'h02);
        check("t1_flags", {30'd0, err_sig, err_len}, 32'd0);
        bsum = 0;
        for (int i = 0; i < 128; i++)
            bsum += mem[i][7:0] + mem[i][15:8] + mem[i][23:16] + mem[i][31:24];
        check("t1_bytesum", bsum & 32'hFF, 32'd0);
        for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];

        // Test 2: short stream, length 2 units, zero-fill to word 255
        clear_mem();
        w0 = wr_cnt;
        pulse_start();
        send_byte(8'h55, 1'b0, 0);
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        for (int i = 0; i < 10; i++) send_byte(8'h11, i == 9, 0);
        wait_done("t2");
        check("t2_writes", wr_cnt - w0, 32'd257);
        check("t2_w0", mem[0], 32'h1102AA55);
        check("t2_w2", mem[2], 32'h11111111);
        check("t2_w3", mem[3], 32'h00000011);
        check("t2_w4", mem[4], 32'h00000000);
        check("t2_w200", mem[200], 32'h00000000);
        // 0x55+0xAA+0x02+10*0x11 = 0xAB (mod 256), so the patch is 0x55
        check("t2_w255", mem[255], 32'h55000000);
        check("t2_w256", mem[256], 32'hDEADBEEF);
        check("t2_cks", {24'd0, checksum}, 32'h55);
        check("t2_flags", {30'd0, err_sig, err_len}, 32'd0);

        // Test 3: bad signature, no fill or fix-up
        clear_mem();
        w0 = wr_cnt; r0 = rd_cnt;
        pulse_start();
        check("t3_cks_cleared", {24'd0, checksum}, 32'd0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'h01, 1'b0, 0);
        for (int i = 3; i < 8; i++) send_byte(8'(i), i == 7, 0);
        wait_done("t3");
        check("t3_writes", wr_cnt - w0, 32'd2);
        check("t3_reads", rd_cnt - r0, 32'd0);
        check("t3_w0", mem[0], 32'h0301AA00);
        check("t3_w1", mem[1], 32'h07060504);
        check("t3_w2", mem[2], 32'hDEADBEEF);
        check("t3_flags", {30'd0, err_sig, err_len}, 32'd2);
        check("t3_cks", {24'd0, checksum}, 32'd0);

        // Test 4: length byte 5 clamps to 4 units; stream overruns 2048 bytes
        clear_mem();
        w0 = wr_cnt; r0 = rd_cnt;
        rdy_miss = 0;
        pulse_start();
        send_byte(8'h55, 1'b0, 0);
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'h05, 1'b0, 0);
        for (int i = 3; i < 2100; i++) send_byte(8'(i), i == 2099, 0);
        check("t4_err_len_early", {31'd0, err_len}, 32'd1);
        wait_done("t4");
        check("t4_ready_held", rdy_miss, 32'd0);
        check("t4_writes", wr_cnt - w0, 32'd513);
        check("t4_reads", rd_cnt - r0, 32'd1);
        check("t4_wr_addr", {23'd0, last_wr_addr}, 32'd511);
        check("t4_rd_addr", {23'd0, last_rd_addr}, 32'd511);
        check("t4_w0", mem[0], 32'h0305AA55);
        // bytes 2044..2046 = FC FD FE; sum of bytes 0..2046 = 0x02 -> patch 0xFE
        check("t4_w511", mem[511], 32'hFEFEFDFC);
        check("t4_cks", {24'd0, checksum}, 32'hFE);
        check("t4_flags", {30'd0, err_sig, err_len}, 32'd1);

        // Test 5: test 1 with random valid gaps
        clear_mem();
        pulse_start();
        run_test1(3);
        wait_done("t5");
        diffs = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("t5_mem_diffs", diffs, 32'd0);
        check("t5_cks", {24'd0, checksum}, 32'h02);

        // Test 6: reset in the middle of a load, then a clean reload
        pulse_start();
        for (int i = 0; i < 37; i++) send_byte(t1_byte(i), 1'b0, 0);
        rst = 1'b1;
        #1;
        check("t6_rst_ctrl", {25'd0, busy, done, err_sig, err_len, bus.in_ready, bus.rom_wren, bus.rom_enable}, 32'd0);
        check("t6_rst_addr_din", {23'd0, bus.rom_address} | bus.rom_din, 32'd0);
        check("t6_rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        @(negedge clk);
        rst = 1'b0;
        clear_mem();
        w0 = wr_cnt;
        pulse_start();
        run_test1(0);
        wait_done("t6");
        check("t6_writes", wr_cnt - w0, 32'd129);
        diffs = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("t6_mem_diffs", diffs, 32'd0);
        check("t6_w127", mem[127], 32'h02FEFDFC);
        check("t6_cks", {24'd0, checksum}, 32'h02);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
